gp_cmd_decoder: RTL

- Consumes the 32-bit command-word stream produced by the GP prefetch FIFO (word_in / fifo_stall).
- Parses the opcode and operand words, then dispatches FILL and LINE commands to the fill and line engines over valid/ready handshakes.
- Drives gp_stall back to the prefetch FIFO so it holds its read pointer while the decoder is busy.
- Signals completion on a STOP opcode.

---
 rtl/gp_pkg.sv | 25 ++
 rtl/gp_operand_unpack.sv | 19 +
 rtl/gp_cmd_decoder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/gp_pkg.sv
// Shared definitions for the GP command decoder: opcodes, FSM encoding,
// default field widths and operand word field positions.
package gp_pkg;

   localparam int GP_COORD_W = 10;
   localparam int GP_COLOR_W = 24;

   localparam logic [7:0] OP_STOP = 8'h00;
   localparam logic [7:0] OP_FILL = 8'h01;
   localparam logic [7:0] OP_LINE = 8'h02;

   localparam int OPCODE_LSB = 24;
   localparam int OPND_X_LSB = 16;
   localparam int OPND_Y_LSB = 0;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_FETCH_OP   = 3'd1,
      ST_FETCH_P0   = 3'd2,
      ST_FETCH_P1   = 3'd3,
      ST_ISSUE_FILL = 3'd4,
      ST_ISSUE_LINE = 3'd5
   } gp_state_e;

endpackage

// File: rtl/gp_operand_unpack.sv
// Splits an operand word into its X and Y coordinate fields.
module gp_operand_unpack
   import gp_pkg::*;
#(
   parameter int COORD_W = GP_COORD_W
) (
   input  logic [31:0]        word_i,
   output logic [COORD_W-1:0] x_o,
   output logic [COORD_W-1:0] y_o
);

   // Bits outside the two coordinate fields carry no meaning.
   logic unused_word_bits;

   assign x_o = word_i[OPND_X_LSB +: COORD_W];
   assign y_o = word_i[OPND_Y_LSB +: COORD_W];
   assign unused_word_bits = ^word_i;

endmodule

// File: rtl/gp_cmd_decoder.sv
// GP command decoder: parses the prefetch FIFO word stream and dispatches
// FILL / LINE commands to their engines over valid/ready handshakes.
//
// state          | meaning
// ---------------+-------------------------------------------------
// ST_IDLE        | waiting for gp_valid to start a command list
// ST_FETCH_OP    | expecting an opcode word
// ST_FETCH_P0    | expecting the first LINE operand (x0/y0)
// ST_FETCH_P1    | expecting the second LINE operand (x1/y1)
// ST_ISSUE_FILL  | fill_valid high, waiting for fill_ready
// ST_ISSUE_LINE  | line_valid high, waiting for line_ready
module gp_cmd_decoder
   import gp_pkg::*;
#(
   parameter int COORD_W = GP_COORD_W,
   parameter int COLOR_W = GP_COLOR_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               gp_valid,
   input  logic               gp_interrupt,
   input  logic [31:0]        word_in,
   input  logic               fifo_stall,
   output logic               gp_stall,
   output logic               fill_valid,
   input  logic               fill_ready,
   output logic [COLOR_W-1:0] fill_color,
   output logic               line_valid,
   input  logic               line_ready,
   output logic [COLOR_W-1:0] line_color,
   output logic [COORD_W-1:0] line_x0,
   output logic [COORD_W-1:0] line_y0,
   output logic [COORD_W-1:0] line_x1,
   output logic [COORD_W-1:0] line_y1,
   output logic               gp_done,
   output logic               gp_err
);

   gp_state_e          state_q, state_d;
   logic [COLOR_W-1:0] fill_color_q, fill_color_d;
   logic [COLOR_W-1:0] line_color_q, line_color_d;
   logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d;
   logic [COORD_W-1:0] x1_q, x1_d, y1_q, y1_d;
   logic               fill_valid_q, line_valid_q;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               in_fetch;
   logic [7:0]         opcode;
   logic [COORD_W-1:0] opnd_x, opnd_y;

   gp_operand_unpack #(.COORD_W(COORD_W)) u_unpack (
      .word_i (word_in),
      .x_o    (opnd_x),
      .y_o    (opnd_y)
   );

   assign opcode   = word_in[OPCODE_LSB +: 8];
   assign in_fetch = (state_q == ST_FETCH_OP) || (state_q == ST_FETCH_P0) ||
                     (state_q == ST_FETCH_P1);
   assign gp_stall = !(in_fetch && !fifo_stall);

   // Next-state and field-latch decode; restart beats abort beats normal flow.
   always_comb begin
      state_d      = state_q;
      fill_color_d = fill_color_q;
      line_color_d = line_color_q;
      x0_d         = x0_q;
      y0_d         = y0_q;
      x1_d         = x1_q;
      y1_d         = y1_q;
      done_d       = 1'b0;
      err_d        = err_q;
      if (gp_valid) begin
         state_d = ST_FETCH_OP;
         err_d   = 1'b0;
      end else if (gp_interrupt) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_FETCH_OP: if (!fifo_stall) begin
               case (opcode)
                  OP_STOP: begin
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end
                  OP_FILL: begin
                     fill_color_d = word_in[COLOR_W-1:0];
                     state_d      = ST_ISSUE_FILL;
                  end
                  OP_LINE: begin
                     line_color_d = word_in[COLOR_W-1:0];
                     state_d      = ST_FETCH_P0;
                  end
                  default: err_d = 1'b1;
               endcase
            end
            ST_FETCH_P0: if (!fifo_stall) begin
               x0_d    = opnd_x;
               y0_d    = opnd_y;
               state_d = ST_FETCH_P1;
            end
            ST_FETCH_P1: if (!fifo_stall) begin
               x1_d    = opnd_x;
               y1_d    = opnd_y;
               state_d = ST_ISSUE_LINE;
            end
            ST_ISSUE_FILL: if (fill_ready) state_d = ST_FETCH_OP;
            ST_ISSUE_LINE: if (line_ready) state_d = ST_FETCH_OP;
            default: ;
         endcase
      end
   end

   // State, latched fields and registered handshake/status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         fill_color_q <= '0;
         line_color_q <= '0;
         x0_q         <= '0;
         y0_q         <= '0;
         x1_q         <= '0;
         y1_q         <= '0;
         fill_valid_q <= 1'b0;
         line_valid_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         fill_color_q <= fill_color_d;
         line_color_q <= line_color_d;
         x0_q         <= x0_d;
         y0_q         <= y0_d;
         x1_q         <= x1_d;
         y1_q         <= y1_d;
         fill_valid_q <= (state_d == ST_ISSUE_FILL);
         line_valid_q <= (state_d == ST_ISSUE_LINE);
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign fill_valid = fill_valid_q;
   assign line_valid = line_valid_q;
   assign fill_color = fill_color_q;
   assign line_color = line_color_q;
   assign line_x0    = x0_q;
   assign line_y0    = y0_q;
   assign line_x1    = x1_q;
   assign line_y1    = y1_q;
   assign gp_done    = done_q;
   assign gp_err     = err_q;

endmodule
